// File: rtl/btn_conditioner.sv
// Push-button / switch conditioner: 2-flop synchronizer, counter debounce,
// press/release edge pulses and a step pulse with hold-to-repeat.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int ACTIVE_LOW_IN   = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   input  logic enable,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic step_pulse,
   output logic repeat_active
);

   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
   localparam logic             PIN_IDLE    = (ACTIVE_LOW_IN != 0);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } state_t;

   logic             sync_p0;
   logic             sync_p1;
   logic             s;
   logic [CNT_W-1:0] db_cnt;
   logic             flip;
   logic             rise;
   logic             fall;
   state_t           state;
   logic [TMR_W-1:0] tmr;

   // Stage p0/p1: synchronizer, parked at the released pin level during reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= PIN_IDLE;
         sync_p1 <= PIN_IDLE;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   // XOR with the idle pin level makes s active-high "pressed"
   assign s = sync_p1 ^ PIN_IDLE;

   always_comb begin
      flip = (s != level) && (db_cnt == DB_LAST);
      rise = flip && !level;
      fall = flip && level;
   end

   // Debounce: level only follows s after DEBOUNCE_CYCLES consecutive disagreeing edges
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt        <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= rise;
         release_pulse <= fall;
         if (s == level) begin
            db_cnt <= '0;
         end else if (flip) begin
            db_cnt <= '0;
            level  <= ~level;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

   // Step FSM reacts to the same edge that moves level, so step aligns with press_pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         tmr           <= '0;
         step_pulse    <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         step_pulse    <= 1'b0;
         repeat_active <= 1'b0;
         case (state)
            IDLE: begin
               tmr <= '0;
               if (rise && enable) begin
                  state      <= HOLD;
                  step_pulse <= 1'b1;
               end
            end
            HOLD: begin
               if (fall || !enable) begin
                  state <= IDLE;
                  tmr   <= '0;
               end else if (tmr == DELAY_LAST) begin
                  // Without auto-repeat the timer parks at terminal count until release
                  if (REPEAT_EN != 0) begin
                     state         <= REPEAT;
                     tmr           <= '0;
                     step_pulse    <= 1'b1;
                     repeat_active <= 1'b1;
                  end
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            REPEAT: begin
               if (fall || !enable) begin
                  state <= IDLE;
                  tmr   <= '0;
               end else begin
                  repeat_active <= 1'b1;
                  if (tmr == PERIOD_LAST) begin
                     tmr        <= '0;
                     step_pulse <= 1'b1;
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               tmr   <= '0;
            end
         endcase
      end
   end

endmodule
